// File: rtl/bsc_axiu_hwcounter_pkg.sv
// Shared register map, response codes and bus FSM state types for the
// multi-channel hardware counter AXI-Lite peripheral.
package bsc_axiu_hwcounter_pkg;

    localparam int unsigned CHAN_STRIDE = 8;
    localparam int unsigned HI_OFFSET   = 4;

    localparam int unsigned ADDR_CTRL   = 'h40;
    localparam int unsigned ADDR_CLEAR  = 'h44;
    localparam int unsigned ADDR_MODE   = 'h48;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_ADDR,
        RD_DATA
    } rd_state_t;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_ADDR,
        WR_RESP
    } wr_state_t;

endpackage

// File: rtl/bsc_axiu_hwcounter_chan.sv
// One counter channel: free-running or event-gated increment, synchronous
// clear, and a snapshot of the upper word taken whenever the low word is read.
module bsc_axiu_hwcounter_chan
    import bsc_axiu_hwcounter_pkg::*;
#(
    parameter int COUNTER_WIDTH = 64
) (
    input  logic        s_axi_aclk,
    input  logic        s_axi_areset,
    input  logic        enable,
    input  logic        mode,
    input  logic        event_in,
    input  logic        clear,
    input  logic        snap,
    output logic [31:0] count_lo,
    output logic [31:0] snapshot
);

    logic [COUNTER_WIDTH-1:0] count;

    // Clear has priority so a clear landing on an active cycle still yields zero.
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (!mode || event_in)) begin
            count <= count + COUNTER_WIDTH'(1);
        end
    end

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            snapshot <= '0;
        end else if (snap) begin
            snapshot <= 32'(count >> 32);
        end
    end

    assign count_lo = count[31:0];

endmodule

// File: rtl/bsc_axiu_hwcounter_multi.sv
// AXI-Lite slave exposing NUM_COUNTERS wide event/cycle counters with
// enable, mode and clear controls and a coherent LO/HI read scheme.
module bsc_axiu_hwcounter_multi
    import bsc_axiu_hwcounter_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 7,
    parameter int NUM_COUNTERS       = 4,
    parameter int COUNTER_WIDTH      = 64
) (
    input  logic                            s_axi_aclk,
    input  logic                            s_axi_areset,

    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    output logic [1:0]                      s_axi_bresp,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,

    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,

    input  logic [NUM_COUNTERS-1:0]         event_in
);

    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int DW = C_S_AXI_DATA_WIDTH;

    logic [AW-1:0]           rd_addr;
    logic [AW-1:0]           wr_addr;
    logic [NUM_COUNTERS-1:0] ctrl_reg;
    logic [NUM_COUNTERS-1:0] mode_reg;
    logic [NUM_COUNTERS-1:0] clear_pulse;
    logic [NUM_COUNTERS-1:0] snap_sel;
    logic [31:0]             chan_lo [NUM_COUNTERS];
    logic [31:0]             chan_hi [NUM_COUNTERS];
    logic [DW-1:0]           rd_data_next;
    logic                    ar_hs;
    logic                    wr_hs;
    logic                    unused_inputs;
    rd_state_t               rd_state;
    wr_state_t               wr_state;

    assign rd_addr = {s_axi_araddr[AW-1:2], 2'b00};
    assign wr_addr = {s_axi_awaddr[AW-1:2], 2'b00};

    assign ar_hs = (rd_state == RD_ADDR) && s_axi_arvalid;
    assign wr_hs = (wr_state == WR_ADDR) && s_axi_awvalid && s_axi_wvalid;

    assign s_axi_rresp = RESP_OKAY;
    assign s_axi_bresp = RESP_OKAY;

    assign unused_inputs = ^{s_axi_wstrb, s_axi_wdata, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    // Anything not matched below (CLEAR, holes, absent channels) reads as zero.
    always_comb begin
        rd_data_next = '0;
        snap_sel     = '0;
        if (rd_addr == AW'(ADDR_CTRL)) begin
            rd_data_next = DW'(ctrl_reg);
        end
        if (rd_addr == AW'(ADDR_MODE)) begin
            rd_data_next = DW'(mode_reg);
        end
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            if (rd_addr == AW'(CHAN_STRIDE * i)) begin
                rd_data_next = DW'(chan_lo[i]);
                snap_sel[i]  = ar_hs;
            end
            if (rd_addr == AW'(CHAN_STRIDE * i + HI_OFFSET)) begin
                rd_data_next = DW'(chan_hi[i]);
            end
        end
    end

    always_comb begin
        clear_pulse = '0;
        if (wr_hs && (wr_addr == AW'(ADDR_CLEAR))) begin
            clear_pulse = s_axi_wdata[NUM_COUNTERS-1:0];
        end
    end

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            ctrl_reg <= '1;
            mode_reg <= '0;
        end else if (wr_hs) begin
            if (wr_addr == AW'(ADDR_CTRL)) begin
                ctrl_reg <= s_axi_wdata[NUM_COUNTERS-1:0];
            end
            if (wr_addr == AW'(ADDR_MODE)) begin
                mode_reg <= s_axi_wdata[NUM_COUNTERS-1:0];
            end
        end
    end

    // ARREADY is a one-cycle pulse issued only while no read response is pending.
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            rd_state      <= RD_IDLE;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= '0;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (s_axi_arvalid) begin
                        s_axi_arready <= 1'b1;
                        rd_state      <= RD_ADDR;
                    end
                end
                RD_ADDR: begin
                    s_axi_arready <= 1'b0;
                    if (s_axi_arvalid) begin
                        s_axi_rdata  <= rd_data_next;
                        s_axi_rvalid <= 1'b1;
                        rd_state     <= RD_DATA;
                    end else begin
                        rd_state <= RD_IDLE;
                    end
                end
                RD_DATA: begin
                    if (s_axi_rready) begin
                        s_axi_rvalid <= 1'b0;
                        rd_state     <= RD_IDLE;
                    end
                end
                default: begin
                    s_axi_arready <= 1'b0;
                    s_axi_rvalid  <= 1'b0;
                    rd_state      <= RD_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            wr_state      <= WR_IDLE;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
        end else begin
            case (wr_state)
                WR_IDLE: begin
                    if (s_axi_awvalid && s_axi_wvalid) begin
                        s_axi_awready <= 1'b1;
                        s_axi_wready  <= 1'b1;
                        wr_state      <= WR_ADDR;
                    end
                end
                WR_ADDR: begin
                    s_axi_awready <= 1'b0;
                    s_axi_wready  <= 1'b0;
                    if (s_axi_awvalid && s_axi_wvalid) begin
                        s_axi_bvalid <= 1'b1;
                        wr_state     <= WR_RESP;
                    end else begin
                        wr_state <= WR_IDLE;
                    end
                end
                WR_RESP: begin
                    if (s_axi_bready) begin
                        s_axi_bvalid <= 1'b0;
                        wr_state     <= WR_IDLE;
                    end
                end
                default: begin
                    s_axi_awready <= 1'b0;
                    s_axi_wready  <= 1'b0;
                    s_axi_bvalid  <= 1'b0;
                    wr_state      <= WR_IDLE;
                end
            endcase
        end
    end

    for (genvar i = 0; i < NUM_COUNTERS; i++) begin : gen_chan
        bsc_axiu_hwcounter_chan #(
            .COUNTER_WIDTH (COUNTER_WIDTH)
        ) u_chan (
            .s_axi_aclk   (s_axi_aclk),
            .s_axi_areset (s_axi_areset),
            .enable       (ctrl_reg[i]),
            .mode         (mode_reg[i]),
            .event_in     (event_in[i]),
            .clear        (clear_pulse[i]),
            .snap         (snap_sel[i]),
            .count_lo     (chan_lo[i]),
            .snapshot     (chan_hi[i])
        );
    end

endmodule

// File: tb/tb_bsc_axiu_hwcounter_multi.sv
// Directed testbench for bsc_axiu_hwcounter_multi with 4 channels of 40 bits.
module tb_bsc_axiu_hwcounter_multi;

    localparam int AW = 7;
    localparam int NC = 4;
    localparam int CW = 40;

    localparam logic [AW-1:0] A_LO0   = 7'h00;
    localparam logic [AW-1:0] A_HI0   = 7'h04;
    localparam logic [AW-1:0] A_LO1   = 7'h08;
    localparam logic [AW-1:0] A_HI1   = 7'h0C;
    localparam logic [AW-1:0] A_LO7   = 7'h38;
    localparam logic [AW-1:0] A_CTRL  = 7'h40;
    localparam logic [AW-1:0] A_CLEAR = 7'h44;
    localparam logic [AW-1:0] A_MODE  = 7'h48;
    localparam logic [AW-1:0] A_MODEX = 7'h4B;
    localparam logic [AW-1:0] A_HOLE  = 7'h4C;

    logic          s_axi_aclk = 1'b0;
    logic          s_axi_areset = 1'b1;
    logic [AW-1:0] s_axi_awaddr = '0;
    logic          s_axi_awvalid = 1'b0;
    logic          s_axi_awready;
    logic [31:0]   s_axi_wdata = '0;
    logic [3:0]    s_axi_wstrb = 4'hF;
    logic          s_axi_wvalid = 1'b0;
    logic          s_axi_wready;
    logic [1:0]    s_axi_bresp;
    logic          s_axi_bvalid;
    logic          s_axi_bready = 1'b1;
    logic [AW-1:0] s_axi_araddr = '0;
    logic          s_axi_arvalid = 1'b0;
    logic          s_axi_arready;
    logic [31:0]   s_axi_rdata;
    logic [1:0]    s_axi_rresp;
    logic          s_axi_rvalid;
    logic          s_axi_rready = 1'b1;
    logic [NC-1:0] event_in = '0;

    int          checks = 0;
    int          failures = 0;
    int unsigned cyc = 0;
    int unsigned rd_edge = 0;
    int unsigned wr_edge = 0;
    logic [31:0] rd_val;
    logic [1:0]  rd_resp;
    logic [1:0]  wr_resp;

    bsc_axiu_hwcounter_multi #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (AW),
        .NUM_COUNTERS       (NC),
        .COUNTER_WIDTH      (CW)
    ) dut (
        .s_axi_aclk    (s_axi_aclk),
        .s_axi_areset  (s_axi_areset),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .event_in      (event_in)
    );

    always #5 s_axi_aclk = ~s_axi_aclk;

    // Edge index: after posedge k (observed #1 later) cyc equals k.
    always @(posedge s_axi_aclk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic axi_read(input logic [AW-1:0] addr);
        int n = 0;
        s_axi_araddr  = addr;
        s_axi_arvalid = 1'b1;
        @(negedge s_axi_aclk);
        while (!s_axi_arready && n < 16) begin
            @(negedge s_axi_aclk);
            n++;
        end
        if (!s_axi_arready) begin
            checks++; failures++;
            $display("[TB] FAIL read_arready_timeout addr=%h", addr);
            s_axi_arvalid = 1'b0;
            rd_val = 'x;
            return;
        end
        @(posedge s_axi_aclk);
        #1;
        rd_edge       = cyc;
        s_axi_arvalid = 1'b0;
        n = 0;
        while (!s_axi_rvalid && n < 16) begin
            @(negedge s_axi_aclk);
            n++;
        end
        if (!s_axi_rvalid) begin
            checks++; failures++;
            $display("[TB] FAIL read_rvalid_timeout addr=%h", addr);
            rd_val = 'x;
            return;
        end
        rd_val  = s_axi_rdata;
        rd_resp = s_axi_rresp;
        @(posedge s_axi_aclk);
        @(negedge s_axi_aclk);
    endtask

    task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data);
        int n = 0;
        s_axi_awaddr  = addr;
        s_axi_wdata   = data;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        @(negedge s_axi_aclk);
        while (!(s_axi_awready && s_axi_wready) && n < 16) begin
            @(negedge s_axi_aclk);
            n++;
        end
        if (!(s_axi_awready && s_axi_wready)) begin
            checks++; failures++;
            $display("[TB] FAIL write_ready_timeout addr=%h", addr);
            s_axi_awvalid = 1'b0;
            s_axi_wvalid  = 1'b0;
            return;
        end
        @(posedge s_axi_aclk);
        #1;
        wr_edge       = cyc;
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        n = 0;
        while (!s_axi_bvalid && n < 16) begin
            @(negedge s_axi_aclk);
            n++;
        end
        if (!s_axi_bvalid) begin
            checks++; failures++;
            $display("[TB] FAIL write_bvalid_timeout addr=%h", addr);
            return;
        end
        wr_resp = s_axi_bresp;
        @(posedge s_axi_aclk);
        @(negedge s_axi_aclk);
    endtask

    task automatic pulse_event(input int ch, input int count);
        for (int k = 0; k < count; k++) begin
            @(negedge s_axi_aclk);
            event_in[ch] = 1'b1;
            @(negedge s_axi_aclk);
            event_in[ch] = 1'b0;
        end
    endtask

    task automatic test_reset;
        @(negedge s_axi_aclk);
        checks++;
        if ({s_axi_arready, s_axi_awready, s_axi_wready} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL reset_readies got=%b exp=000", {s_axi_arready, s_axi_awready, s_axi_wready});
        end
        checks++;
        if ({s_axi_rvalid, s_axi_bvalid} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL reset_valids got=%b exp=00", {s_axi_rvalid, s_axi_bvalid});
        end
        checks++;
        if (s_axi_rdata !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_rdata got=%h exp=00000000", s_axi_rdata);
        end
        s_axi_areset = 1'b0;
        repeat (99) @(negedge s_axi_aclk);
        axi_read(A_LO0);
        checks++;
        if (rd_val !== 32'd100 || rd_resp !== 2'b00) begin
            failures++;
            $display("[TB] FAIL reset_lo0 got=%0d/%b exp=100/00", rd_val, rd_resp);
        end
        axi_read(A_HI0);
        checks++;
        if (rd_val !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_hi0 got=%h exp=00000000", rd_val);
        end
        axi_read(A_CTRL);
        checks++;
        if (rd_val !== 32'hF) begin
            failures++;
            $display("[TB] FAIL reset_ctrl got=%h exp=0000000f", rd_val);
        end
        axi_read(A_MODE);
        checks++;
        if (rd_val !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_mode got=%h exp=00000000", rd_val);
        end
    endtask

    task automatic test_clear;
        int unsigned clr_edge;
        logic [31:0] exp_lo;
        axi_write(A_CLEAR, 32'h1);
        clr_edge = wr_edge;
        checks++;
        if (wr_resp !== 2'b00) begin
            failures++;
            $display("[TB] FAIL clear_bresp got=%b exp=00", wr_resp);
        end
        repeat (20) @(negedge s_axi_aclk);
        axi_read(A_LO0);
        exp_lo = rd_edge - clr_edge - 1;
        checks++;
        if (rd_val !== exp_lo) begin
            failures++;
            $display("[TB] FAIL clear_lo0 got=%0d exp=%0d", rd_val, exp_lo);
        end
    endtask

    task automatic test_wrap;
        logic [63:0] total;
        logic [31:0] exp_hi;
        axi_write(A_CTRL, 32'hE);
        force dut.gen_chan[0].u_chan.count = 40'h00_FFFF_FF80;
        @(negedge s_axi_aclk);
        release dut.gen_chan[0].u_chan.count;
        axi_write(A_CTRL, 32'hF);
        repeat (150) @(negedge s_axi_aclk);
        axi_read(A_LO0);
        total  = 64'h00_FFFF_FF80 + 64'(rd_edge - 1 - wr_edge);
        exp_hi = {24'd0, total[39:32]};
        checks++;
        if (rd_val !== total[31:0]) begin
            failures++;
            $display("[TB] FAIL cross_lo0 got=%h exp=%h", rd_val, total[31:0]);
        end
        axi_read(A_HI0);
        checks++;
        if (rd_val !== 32'h1 || exp_hi !== 32'h1) begin
            failures++;
            $display("[TB] FAIL cross_hi0 got=%h exp=00000001", rd_val);
        end
        repeat (50) @(negedge s_axi_aclk);
        axi_read(A_HI0);
        checks++;
        if (rd_val !== 32'h1) begin
            failures++;
            $display("[TB] FAIL cross_hi0_persist got=%h exp=00000001", rd_val);
        end
        axi_write(A_CLEAR, 32'h1);
        axi_read(A_HI0);
        checks++;
        if (rd_val !== 32'h1) begin
            failures++;
            $display("[TB] FAIL hi0_not_live got=%h exp=00000001", rd_val);
        end
        axi_read(A_LO0);
        axi_read(A_HI0);
        checks++;
        if (rd_val !== 32'h0) begin
            failures++;
            $display("[TB] FAIL hi0_after_lo got=%h exp=00000000", rd_val);
        end
        axi_write(A_CTRL, 32'hE);
        force dut.gen_chan[0].u_chan.count = 40'hFF_FFFF_FFF0;
        @(negedge s_axi_aclk);
        release dut.gen_chan[0].u_chan.count;
        axi_write(A_CTRL, 32'hF);
        repeat (30) @(negedge s_axi_aclk);
        axi_read(A_LO0);
        total = (64'hFF_FFFF_FFF0 + 64'(rd_edge - 1 - wr_edge)) & 64'hFF_FFFF_FFFF;
        checks++;
        if (rd_val !== total[31:0]) begin
            failures++;
            $display("[TB] FAIL wrap_lo0 got=%h exp=%h", rd_val, total[31:0]);
        end
        axi_read(A_HI0);
        checks++;
        if (rd_val !== {24'd0, total[39:32]}) begin
            failures++;
            $display("[TB] FAIL wrap_hi0 got=%h exp=%h", rd_val, {24'd0, total[39:32]});
        end
    endtask

    task automatic test_event_mode;
        axi_write(A_MODE, 32'h2);
        axi_write(A_CLEAR, 32'h2);
        pulse_event(1, 7);
        axi_read(A_LO1);
        checks++;
        if (rd_val !== 32'd7) begin
            failures++;
            $display("[TB] FAIL event_lo1 got=%0d exp=7", rd_val);
        end
        axi_write(A_CTRL, 32'hD);
        pulse_event(1, 5);
        axi_read(A_LO1);
        checks++;
        if (rd_val !== 32'd7) begin
            failures++;
            $display("[TB] FAIL event_disabled_lo1 got=%0d exp=7", rd_val);
        end
        axi_read(A_HI1);
        checks++;
        if (rd_val !== 32'h0) begin
            failures++;
            $display("[TB] FAIL event_hi1 got=%h exp=00000000", rd_val);
        end
    endtask

    task automatic test_unmapped;
        axi_write(A_HOLE, 32'hFFFF_FFFF);
        checks++;
        if (wr_resp !== 2'b00) begin
            failures++;
            $display("[TB] FAIL hole_bresp got=%b exp=00", wr_resp);
        end
        axi_read(A_CTRL);
        checks++;
        if (rd_val !== 32'hD) begin
            failures++;
            $display("[TB] FAIL hole_ctrl_kept got=%h exp=0000000d", rd_val);
        end
        axi_read(A_MODEX);
        checks++;
        if (rd_val !== 32'h2) begin
            failures++;
            $display("[TB] FAIL mode_lowbits got=%h exp=00000002", rd_val);
        end
        axi_write(A_CTRL, 32'hFFFF_FFFF);
        axi_read(A_CTRL);
        checks++;
        if (rd_val !== 32'hF) begin
            failures++;
            $display("[TB] FAIL ctrl_upper_zero got=%h exp=0000000f", rd_val);
        end
        axi_read(A_HOLE);
        checks++;
        if (rd_val !== 32'h0 || rd_resp !== 2'b00) begin
            failures++;
            $display("[TB] FAIL read_4c got=%h/%b exp=00000000/00", rd_val, rd_resp);
        end
        axi_read(A_LO7);
        checks++;
        if (rd_val !== 32'h0 || rd_resp !== 2'b00) begin
            failures++;
            $display("[TB] FAIL read_38 got=%h/%b exp=00000000/00", rd_val, rd_resp);
        end
        axi_read(A_CLEAR);
        checks++;
        if (rd_val !== 32'h0) begin
            failures++;
            $display("[TB] FAIL read_clear got=%h exp=00000000", rd_val);
        end
    endtask

    task automatic test_back_to_back;
        s_axi_araddr  = A_MODE;
        s_axi_arvalid = 1'b1;
        s_axi_awaddr  = A_MODE;
        s_axi_wdata   = 32'h0;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        @(negedge s_axi_aclk);
        checks++;
        if ({s_axi_arready, s_axi_awready, s_axi_wready} !== 3'b111) begin
            failures++;
            $display("[TB] FAIL concurrent_ready got=%b exp=111", {s_axi_arready, s_axi_awready, s_axi_wready});
        end
        @(posedge s_axi_aclk);
        #1;
        s_axi_arvalid = 1'b0;
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        checks++;
        if ({s_axi_rvalid, s_axi_bvalid} !== 2'b11 || s_axi_rdata !== 32'h2) begin
            failures++;
            $display("[TB] FAIL concurrent_preread got=%b/%h exp=11/00000002", {s_axi_rvalid, s_axi_bvalid}, s_axi_rdata);
        end
        @(posedge s_axi_aclk);
        @(negedge s_axi_aclk);
        axi_read(A_MODE);
        checks++;
        if (rd_val !== 32'h0) begin
            failures++;
            $display("[TB] FAIL concurrent_postread got=%h exp=00000000", rd_val);
        end
    endtask

    task automatic test_reset_abort;
        int n = 0;
        int bad = 0;
        axi_write(A_CTRL, 32'h3);
        s_axi_rready  = 1'b0;
        s_axi_araddr  = A_CTRL;
        s_axi_arvalid = 1'b1;
        @(negedge s_axi_aclk);
        while (!s_axi_arready && n < 16) begin
            @(negedge s_axi_aclk);
            n++;
        end
        @(posedge s_axi_aclk);
        #1;
        s_axi_arvalid = 1'b0;
        repeat (3) @(negedge s_axi_aclk);
        checks++;
        if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== 32'h3) begin
            failures++;
            $display("[TB] FAIL abort_hold got=%b/%h exp=1/00000003", s_axi_rvalid, s_axi_rdata);
        end
        s_axi_areset = 1'b1;
        #1;
        checks++;
        if (s_axi_rvalid !== 1'b0 || s_axi_rdata !== 32'h0) begin
            failures++;
            $display("[TB] FAIL abort_drop got=%b/%h exp=0/00000000", s_axi_rvalid, s_axi_rdata);
        end
        repeat (2) @(negedge s_axi_aclk);
        s_axi_areset = 1'b0;
        s_axi_rready = 1'b1;
        repeat (6) begin
            @(negedge s_axi_aclk);
            if (s_axi_rvalid || s_axi_bvalid || s_axi_arready) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("[TB] FAIL abort_no_response got=%0d exp=0", bad);
        end
        axi_read(A_CTRL);
        checks++;
        if (rd_val !== 32'hF) begin
            failures++;
            $display("[TB] FAIL abort_ctrl got=%h exp=0000000f", rd_val);
        end
    endtask

    initial begin
        $display("[TB] start");
        test_reset;
        test_clear;
        test_wrap;
        test_event_mode;
        test_unmapped;
        test_back_to_back;
        test_reset_abort;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
